// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Reset defaults reproduce the legacy overlapping "1101" detector.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int         DEFAULT_LEN     = 4;
  localparam logic       DEFAULT_OVERLAP = 1'b1;

  // Compare path is built at this fixed width so helpers stay parameter-free.
  localparam int MASK_W = 64;

  function automatic int clamp_len(input int cfg_len, input int max_len);
    return (cfg_len > max_len) ? max_len : cfg_len;
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    if (len >= MASK_W) return '1;
    if (len <= 0) return '0;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_detector_param_counter.sv
// Saturating match counter; clear wins over a coincident increment.
module seq_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with registered match pulse
// and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0]   FILL_MAX  = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(DEFAULT_PATTERN);
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
  logic               out_q;
  logic               accept;
  logic               match;
  logic [MASK_W-1:0]  diff;

  assign accept = data_valid && !cfg_load;
  assign hist_n = {hist_q[MAX_LEN-2:0], data_in};
  assign fill_n = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);

  // Bits above len_q are masked off so stale history never affects a match.
  assign diff  = (MASK_W'(hist_n) ^ MASK_W'(pattern_q)) & len_mask(int'(len_q));
  assign match = accept && (len_q != '0) && (fill_n >= len_q) && (diff == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept) begin
      if (match && !overlap_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_n;
        fill_d = fill_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= RST_PAT;
      len_q     <= RST_LEN;
      overlap_q <= DEFAULT_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= match;
    end
  end

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (match),
    .clr_i (count_clr),
    .cnt_o (match_count)
  );

  assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default 16-bit counter build plus a
// 2-bit counter build for saturation and clear-priority checks.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main DUT: MAX_LEN=8, CNT_W=16
  logic        reset, cfg_load, cfg_overlap, data_valid, data_in, count_clr;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        out;
  logic [15:0] match_count;

  // Small-counter DUT: MAX_LEN=8, CNT_W=2
  logic        reset2, cfg_load2, cfg_overlap2, data_valid2, data_in2, count_clr2;
  logic [7:0]  cfg_pattern2;
  logic [3:0]  cfg_len2;
  logic        out2;
  logic [1:0]  match_count2;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_valid(data_valid),
    .data_in(data_in), .count_clr(count_clr), .out(out), .match_count(match_count)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .cfg_load(cfg_load2), .cfg_pattern(cfg_pattern2),
    .cfg_len(cfg_len2), .cfg_overlap(cfg_overlap2), .data_valid(data_valid2),
    .data_in(data_in2), .count_clr(count_clr2), .out(out2), .match_count(match_count2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock on the main DUT, then check out and match_count just after the edge.
  task automatic beat(input logic v, input logic d, input logic exp_out, input logic [15:0] exp_cnt);
    data_valid = v;
    data_in    = d;
    @(posedge clk); #1;
    chk("out", {15'd0, out}, {15'd0, exp_out});
    chk("count", match_count, exp_cnt);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic [15:0] exp_cnt);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    beat(1'b1, 1'b1, 1'b0, exp_cnt);
    cfg_load    = 1'b0;
  endtask

  task automatic beat2(input logic d, input logic clr, input logic exp_out, input logic [1:0] exp_cnt);
    data_valid2 = 1'b1;
    data_in2    = d;
    count_clr2  = clr;
    @(posedge clk); #1;
    chk("out2", {15'd0, out2}, {15'd0, exp_out});
    chk("count2", {14'd0, match_count2}, {14'd0, exp_cnt});
    count_clr2  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    data_valid = 1'b0; data_in = 1'b0; count_clr = 1'b0;
    reset2 = 1'b1; cfg_load2 = 1'b0; cfg_pattern2 = '0; cfg_len2 = '0; cfg_overlap2 = 1'b0;
    data_valid2 = 1'b0; data_in2 = 1'b0; count_clr2 = 1'b0;

    // Reset state, with data_valid high to prove reset wins.
    beat(1'b1, 1'b1, 1'b0, 16'd0);
    beat(1'b1, 1'b1, 1'b0, 16'd0);
    reset = 1'b0;

    // 1: default 1101 overlapping, stream 1101101
    beat(1, 1, 0, 0); beat(1, 1, 0, 0); beat(1, 0, 0, 0); beat(1, 1, 1, 1);
    beat(1, 1, 0, 1); beat(1, 0, 0, 1); beat(1, 1, 1, 2);
    beat(0, 1, 0, 2);

    // 2: non-overlapping 1101
    count_clr = 1'b1; beat(0, 0, 0, 0); count_clr = 1'b0;
    load(8'h0D, 4'd4, 1'b0, 0);
    beat(1, 1, 0, 0); beat(1, 1, 0, 0); beat(1, 0, 0, 0); beat(1, 1, 1, 1);
    beat(1, 1, 0, 1); beat(1, 0, 0, 1); beat(1, 1, 0, 1);
    beat(1, 1, 0, 1); beat(1, 1, 0, 1); beat(1, 0, 0, 1); beat(1, 1, 1, 2);

    // 3: 8-bit A5 with a 3-cycle gap after bit 3
    load(8'hA5, 4'd8, 1'b1, 2);
    beat(1, 1, 0, 2); beat(1, 0, 0, 2); beat(1, 1, 0, 2);
    beat(0, 1, 0, 2); beat(0, 1, 0, 2); beat(0, 0, 0, 2);
    beat(1, 0, 0, 2); beat(1, 0, 0, 2); beat(1, 1, 0, 2); beat(1, 0, 0, 2); beat(1, 1, 1, 3);
    beat(0, 0, 0, 3);

    // 4: cfg_load mid-sequence restarts detection
    load(8'h0D, 4'd4, 1'b1, 3);
    beat(1, 1, 0, 3); beat(1, 1, 0, 3); beat(1, 0, 0, 3);
    load(8'h0D, 4'd4, 1'b1, 3);
    beat(1, 1, 0, 3);
    beat(1, 1, 0, 3); beat(1, 1, 0, 3); beat(1, 0, 0, 3); beat(1, 1, 1, 4);

    // 6a: length 0 disables detection
    load(8'h00, 4'd0, 1'b1, 4);
    beat(1, 0, 0, 4); beat(1, 0, 0, 4); beat(1, 0, 0, 4); beat(1, 0, 0, 4);
    beat(1, 1, 0, 4); beat(1, 0, 0, 4);

    // 6b: length 15 clamps to 8
    load(8'hA5, 4'd15, 1'b1, 4);
    beat(1, 1, 0, 4); beat(1, 0, 0, 4); beat(1, 1, 0, 4); beat(1, 0, 0, 4);
    beat(1, 0, 0, 4); beat(1, 1, 0, 4); beat(1, 0, 0, 4); beat(1, 1, 1, 5);
    beat(1, 0, 0, 5);

    // 6c: reset mid-stream restores defaults
    beat(1, 1, 0, 5); beat(1, 1, 0, 5); beat(1, 0, 0, 5);
    reset = 1'b1; beat(1, 1, 0, 0); reset = 1'b0;
    beat(1, 1, 0, 0); beat(1, 1, 0, 0); beat(1, 0, 0, 0); beat(1, 1, 1, 1);

    // 5: 2-bit counter saturation and clear priority, len 1 pattern 1
    reset2 = 1'b0;
    cfg_pattern2 = 8'h01; cfg_len2 = 4'd1; cfg_overlap2 = 1'b1; cfg_load2 = 1'b1;
    data_valid2 = 1'b1; data_in2 = 1'b1;
    @(posedge clk); #1;
    chk("out2_load", {15'd0, out2}, 16'd0);
    cfg_load2 = 1'b0;
    beat2(1, 0, 1, 2'd1); beat2(1, 0, 1, 2'd2); beat2(1, 0, 1, 2'd3);
    beat2(1, 0, 1, 2'd3); beat2(1, 0, 1, 2'd3);
    beat2(1, 1, 1, 2'd0);
    beat2(0, 0, 0, 2'd0);
    beat2(1, 0, 1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
